// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the external 4-bit Decode_And_Execute ALU.
// Owns a 4x4 register file, issues one instruction at a time and hands results off.
module alu_issue_ctrl #(
    parameter int unsigned DW    = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [8:0]       in_instr,
    output logic             in_ready,
    input  logic             ld_en,
    input  logic [1:0]       ld_addr,
    input  logic [DW-1:0]    ld_data,
    output logic [2:0]       alu_sel,
    output logic [DW-1:0]    alu_rs,
    output logic [DW-1:0]    alu_rt,
    input  logic [DW-1:0]    alu_rd,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    output logic [1:0]       out_rd,
    input  logic             out_ready,
    output logic [CNT_W-1:0] retired,
    input  logic [1:0]       dbg_addr,
    output logic [DW-1:0]    dbg_data
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_retire;

    logic [DW-1:0]     r_rf [4];
    logic [1:0]        r_rd;
    logic [2:0]        r_alu_sel;
    logic [DW-1:0]     r_alu_rs;
    logic [DW-1:0]     r_alu_rt;
    logic              r_out_valid;
    logic [DW-1:0]     r_out_data;
    logic [1:0]        r_out_rd;
    logic [CNT_W-1:0]  r_retired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_in_ready = 1'b0;
        w_accept   = 1'b0;
        w_retire   = 1'b0;
        unique case (r_state)
            StIdle: begin
                // A pending register load takes priority over instruction issue.
                w_in_ready = !ld_en;
                if (!ld_en && in_valid) begin
                    w_accept  = 1'b1;
                    w_state_d = StExec;
                end
            end
            StExec: begin
                w_state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    w_retire  = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_rf[i] <= '0;
            end
            r_rd        <= '0;
            r_alu_sel   <= '0;
            r_alu_rs    <= '0;
            r_alu_rt    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_rd    <= '0;
            r_retired   <= '0;
        end else begin
            if (r_state == StIdle && ld_en) begin
                r_rf[ld_addr] <= ld_data;
            end
            if (w_accept) begin
                r_alu_sel <= in_instr[8:6];
                r_rd      <= in_instr[5:4];
                r_alu_rs  <= r_rf[in_instr[3:2]];
                r_alu_rt  <= r_rf[in_instr[1:0]];
            end
            // The ALU is combinational: its result is settled during EXEC.
            if (r_state == StExec) begin
                r_rf[r_rd]  <= alu_rd;
                r_out_data  <= alu_rd;
                r_out_rd    <= r_rd;
                r_out_valid <= 1'b1;
            end
            if (w_retire) begin
                r_out_valid <= 1'b0;
                r_retired   <= r_retired + CNT_W'(1);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign alu_sel   = r_alu_sel;
    assign alu_rs    = r_alu_rs;
    assign alu_rt    = r_alu_rt;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_rd    = r_out_rd;
    assign retired   = r_retired;
    assign dbg_data  = r_rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural model of the external ALU.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [8:0] in_instr;
    logic       in_ready;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic [2:0] alu_sel;
    logic [3:0] alu_rs;
    logic [3:0] alu_rt;
    logic [3:0] alu_rd;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] out_rd;
    logic       out_ready;
    logic [7:0] retired;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return {a[2:0], a[3]};
            3'd5:    return {b[3], b[3:1]};
            3'd6:    return (a == b) ? 4'b1111 : 4'b1110;
            default: return (a > b) ? 4'b1011 : 4'b1010;
        endcase
    endfunction

    assign alu_rd = alu_ref(alu_sel, alu_rs, alu_rt);

    alu_issue_ctrl #(
        .DW    (4),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .alu_sel   (alu_sel),
        .alu_rs    (alu_rs),
        .alu_rt    (alu_rt),
        .alu_rd    (alu_rd),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_ready (out_ready),
        .retired   (retired),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    typedef struct {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[12];
    logic [3:0] m_rf[4];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic dbg_chk(input string name, input logic [1:0] a, input logic [3:0] exp);
        dbg_addr = a;
        #1;
        chk(name, int'(dbg_data), int'(exp));
    endtask

    task automatic load(input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Returns at the negedge where out_valid is first seen (DONE state).
    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [1:0] rt, output logic [3:0] data,
                         output logic [1:0] rdo, output int lat);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = {op, rd, rs, rt};
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) chk("result_timeout", 0, 1);
        data = out_data;
        rdo  = out_rd;
    endtask

    initial begin
        logic [3:0] d;
        logic [1:0] r;
        int         lat;
        logic [1:0] xrd, xrs, xrt;
        logic [3:0] xexp;

        tbl[0]  = '{3'd6, 2'd3, 2'd0, 2'd1, 4'hF};
        tbl[1]  = '{3'd7, 2'd2, 2'd3, 2'd0, 4'hB};
        tbl[2]  = '{3'd1, 2'd0, 2'd0, 2'd3, 4'hA};
        tbl[3]  = '{3'd2, 2'd1, 2'd2, 2'd3, 4'hB};
        tbl[4]  = '{3'd3, 2'd1, 2'd0, 2'd1, 4'hB};
        tbl[5]  = '{3'd4, 2'd2, 2'd0, 2'd0, 4'h5};
        tbl[6]  = '{3'd5, 2'd3, 2'd3, 2'd0, 4'hD};
        tbl[7]  = '{3'd5, 2'd3, 2'd0, 2'd2, 4'h2};
        tbl[8]  = '{3'd0, 2'd0, 2'd3, 2'd3, 4'h4};
        tbl[9]  = '{3'd7, 2'd1, 2'd0, 2'd0, 4'hA};
        tbl[10] = '{3'd6, 2'd0, 2'd0, 2'd0, 4'hF};
        tbl[11] = '{3'd0, 2'd2, 2'd0, 2'd1, 4'h9};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        out_ready = 1'b1;
        dbg_addr  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_retired", int'(retired), 0);
        chk("rst_alu_sel", int'(alu_sel), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 4; i++) dbg_chk("rst_rf", 2'(i), 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First add, latency and retire count
        load(2'd0, 4'b0011);
        load(2'd1, 4'b0101);
        issue(3'd0, 2'd2, 2'd0, 2'd1, d, r, lat);
        chk("t1_latency", lat, 2);
        chk("t1_data", int'(d), 8);
        chk("t1_rd", int'(r), 2);
        dbg_chk("t1_rf2", 2'd2, 4'b1000);
        @(negedge clk);
        chk("t1_retired", int'(retired), 1);
        chk("t1_valid_drop", int'(out_valid), 0);

        // Directed table covering every op
        load(2'd0, 4'b1001);
        load(2'd1, 4'b1001);
        for (int i = 0; i < 12; i++) begin
            issue(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].rt, d, r, lat);
            chk("tbl_data", int'(d), int'(tbl[i].exp));
            chk("tbl_rd", int'(r), int'(tbl[i].rd));
            dbg_chk("tbl_rf", tbl[i].rd, tbl[i].exp);
        end
        @(negedge clk);
        chk("tbl_retired", int'(retired), 13);

        // Backpressure in DONE with another instruction waiting (rf: F,A,9,2)
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = {3'd3, 2'd1, 2'd2, 2'd3};
        @(posedge clk);
        @(negedge clk);
        in_instr = {3'd0, 2'd0, 2'd0, 2'd0};
        @(negedge clk);
        chk("bp_valid", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_data", int'(out_data), 4'hB);
            chk("bp_sel", int'(alu_sel), 3);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_valid_drop", int'(out_valid), 0);
        chk("bp_retired", int'(retired), 14);
        chk("bp_idle_ready", int'(in_ready), 1);

        // Load and issue requested together: load wins, issue follows
        ld_en    = 1'b1;
        ld_addr  = 2'd3;
        ld_data  = 4'h7;
        in_valid = 1'b1;
        in_instr = {3'd0, 2'd0, 2'd3, 2'd3};
        #1;
        chk("ld_in_ready", int'(in_ready), 0);
        @(negedge clk);
        dbg_chk("ld_rf3", 2'd3, 4'h7);
        chk("ld_not_taken", int'(alu_sel), 3);
        ld_en = 1'b0;
        #1;
        chk("ld_ready_after", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ld_issue_sel", int'(alu_sel), 0);
        chk("ld_issue_rs", int'(alu_rs), 7);
        @(negedge clk);
        chk("ld_issue_data", int'(out_data), 4'hE);
        @(negedge clk);
        chk("ld_retired", int'(retired), 15);

        // Reset during EXEC drops the in-flight op (rf: E,B,9,7)
        in_valid = 1'b1;
        in_instr = {3'd3, 2'd1, 2'd2, 2'd3};
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("ar_valid", int'(out_valid), 0);
        chk("ar_retired", int'(retired), 0);
        chk("ar_sel", int'(alu_sel), 0);
        dbg_chk("ar_rf1", 2'd1, 4'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("ar_post_valid", int'(out_valid), 0);
        chk("ar_post_ready", int'(in_ready), 1);
        dbg_chk("ar_post_rf1", 2'd1, 4'h0);

        // 256 AND ops, retired counter wraps
        m_rf[0] = 4'hF; m_rf[1] = 4'hC; m_rf[2] = 4'h7; m_rf[3] = 4'hA;
        for (int i = 0; i < 4; i++) load(2'(i), m_rf[i]);
        for (int i = 0; i < 256; i++) begin
            xrs  = 2'(i);
            xrt  = 2'(i >> 2);
            xrd  = 2'(i >> 4);
            xexp = m_rf[xrs] & m_rf[xrt];
            m_rf[xrd] = xexp;
            issue(3'd2, xrd, xrs, xrt, d, r, lat);
            chk("wrap_data", int'(d), int'(xexp));
            if (i == 127) chk("wrap_mid_retired", int'(retired), 127);
            // Refill so AND results do not collapse to zero
            if (i % 16 == 15) begin
                @(negedge clk);
                m_rf[xrd] = 4'(i) ^ 4'h9;
                load(xrd, m_rf[xrd]);
            end
        end
        @(negedge clk);
        chk("wrap_retired", int'(retired), 0);
        for (int i = 0; i < 4; i++) dbg_chk("wrap_rf", 2'(i), m_rf[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
